// File: rtl/eth_rx_pkg.sv
// Shared constants, header offsets and types for the Ethernet/IPv4/UDP receive path.
package eth_rx_pkg;

    localparam int unsigned CNT_W = 11;

    localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
    localparam logic [7:0]  SFD_BYTE       = 8'hD5;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [15:0] UDP_HDR_LEN    = 16'd8;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    // Offsets counted from the first byte after the SFD
    localparam logic [CNT_W-1:0] OFF_MAC_LAST     = 11'd5;
    localparam logic [CNT_W-1:0] OFF_ETYPE_HI     = 11'd12;
    localparam logic [CNT_W-1:0] OFF_ETH_LAST     = 11'd13;
    localparam logic [CNT_W-1:0] OFF_IP_VER       = 11'd14;
    localparam logic [CNT_W-1:0] OFF_IP_PROTO     = 11'd23;
    localparam logic [CNT_W-1:0] OFF_IP_DST_FIRST = 11'd30;
    localparam logic [CNT_W-1:0] OFF_IP_LAST      = 11'd33;
    localparam logic [CNT_W-1:0] OFF_UDP_DPORT_HI = 11'd36;
    localparam logic [CNT_W-1:0] OFF_UDP_DPORT_LO = 11'd37;
    localparam logic [CNT_W-1:0] OFF_UDP_LEN_HI   = 11'd38;
    localparam logic [CNT_W-1:0] OFF_UDP_LEN_LO   = 11'd39;
    localparam logic [CNT_W-1:0] OFF_UDP_LAST     = 11'd41;

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TRAIL, DROP
    } rx_state_e;

    typedef struct packed {
        logic [7:0] data;
        logic       sop;
        logic       eop;
    } pay_beat_t;

    // Byte idx (0 = MSB) of a 48-bit big-endian field
    function automatic logic [7:0] be_byte(input logic [47:0] v, input logic [2:0] idx);
        logic [5:0]  sh;
        logic [47:0] s;
        sh = {3'd0, 3'd5 - idx} << 3;
        s  = v >> sh;
        return s[7:0];
    endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide reflected CRC-32 (0xEDB88320) with registered state; shared by rx and tx paths.
module eth_crc32
    import eth_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    logic [31:0] crc_nxt;

    always_comb begin
        crc_nxt = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            crc_nxt = crc_nxt[0] ? ((crc_nxt >> 1) ^ CRC_POLY) : (crc_nxt >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc <= '0;
        end else if (init) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc_nxt;
        end
    end

endmodule

// File: rtl/udp_rx_parser.sv
// Ethernet/IPv4/UDP receive parser: strips preamble, filters headers, streams payload, checks FCS.
module udp_rx_parser
    import eth_rx_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_01,
    parameter logic [31:0] LOCAL_IP   = 32'hC0A8_010A,
    parameter logic [15:0] LOCAL_PORT = 16'd5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_er,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_sop,
    output logic        out_eop,
    output logic        pkt_done,
    output logic        pkt_good,
    output logic [15:0] drop_cnt
);

    rx_state_e        state, state_nxt;
    logic [CNT_W-1:0] byte_cnt;
    logic             mac_local_ok, mac_bcast_ok;
    logic             local_byte_ok, bcast_byte_ok;
    logic [2:0]       ip_idx;
    logic [15:0]      udp_len, pay_rem;
    logic             first_pay, er_seen;
    logic [2:0]       trail_cnt;
    logic             hdr_fail;
    logic             crc_init, crc_en, drop_inc;
    logic [31:0]      crc;
    pay_beat_t        beat_d;
    logic             out_valid_d, pkt_done_d, pkt_good_d;

    eth_crc32 u_crc (
        .clk  (clk),
        .rst  (rst),
        .init (crc_init),
        .en   (crc_en),
        .data (rx_data),
        .crc  (crc)
    );

    // Header field check for the byte at the current offset
    always_comb begin
        local_byte_ok = (rx_data == be_byte(LOCAL_MAC, byte_cnt[2:0]));
        bcast_byte_ok = (rx_data == 8'hFF);
        ip_idx        = 3'(byte_cnt - OFF_IP_DST_FIRST + 11'd2);
        hdr_fail      = 1'b0;
        if (byte_cnt <= OFF_MAC_LAST) begin
            hdr_fail = !(mac_local_ok && local_byte_ok) && !(mac_bcast_ok && bcast_byte_ok);
        end else if (byte_cnt >= OFF_IP_DST_FIRST && byte_cnt <= OFF_IP_LAST) begin
            hdr_fail = (rx_data != be_byte({16'd0, LOCAL_IP}, ip_idx));
        end else begin
            case (byte_cnt)
                OFF_ETYPE_HI:     hdr_fail = (rx_data != ETHERTYPE_IPV4[15:8]);
                OFF_ETH_LAST:     hdr_fail = (rx_data != ETHERTYPE_IPV4[7:0]);
                OFF_IP_VER:       hdr_fail = (rx_data != IP_VER_IHL);
                OFF_IP_PROTO:     hdr_fail = (rx_data != IP_PROTO_UDP);
                OFF_UDP_DPORT_HI: hdr_fail = (rx_data != LOCAL_PORT[15:8]);
                OFF_UDP_DPORT_LO: hdr_fail = (rx_data != LOCAL_PORT[7:0]);
                OFF_UDP_LEN_LO:   hdr_fail = ({udp_len[15:8], rx_data} < UDP_HDR_LEN);
                default:          hdr_fail = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        drop_inc  = 1'b0;
        crc_init  = 1'b0;
        crc_en    = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid) begin
                    if (rx_data == PREAMBLE_BYTE) begin
                        state_nxt = PREAMBLE;
                    end else if (rx_data == SFD_BYTE) begin
                        state_nxt = ETH_HDR;
                        crc_init  = 1'b1;
                    end else begin
                        state_nxt = DROP;
                        drop_inc  = 1'b1;
                    end
                end
            end
            PREAMBLE: begin
                if (!rx_valid) begin
                    state_nxt = IDLE;
                    drop_inc  = 1'b1;
                end else if (rx_er) begin
                    state_nxt = DROP;
                    drop_inc  = 1'b1;
                end else if (rx_data == SFD_BYTE) begin
                    state_nxt = ETH_HDR;
                    crc_init  = 1'b1;
                end else if (rx_data != PREAMBLE_BYTE) begin
                    state_nxt = DROP;
                    drop_inc  = 1'b1;
                end
            end
            ETH_HDR, IP_HDR, UDP_HDR: begin
                if (!rx_valid) begin
                    state_nxt = IDLE;
                    drop_inc  = 1'b1;
                end else begin
                    crc_en = 1'b1;
                    if (rx_er || hdr_fail) begin
                        state_nxt = DROP;
                        drop_inc  = 1'b1;
                    end else if (byte_cnt == OFF_ETH_LAST) begin
                        state_nxt = IP_HDR;
                    end else if (byte_cnt == OFF_IP_LAST) begin
                        state_nxt = UDP_HDR;
                    end else if (byte_cnt == OFF_UDP_LAST) begin
                        state_nxt = (udp_len == UDP_HDR_LEN) ? TRAIL : PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (!rx_valid) begin
                    state_nxt = IDLE;
                end else begin
                    crc_en = 1'b1;
                    if (pay_rem == 16'd1) state_nxt = TRAIL;
                end
            end
            TRAIL: begin
                if (!rx_valid) state_nxt = IDLE;
                else           crc_en    = 1'b1;
            end
            DROP: begin
                if (!rx_valid) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        beat_d      = '0;
        out_valid_d = 1'b0;
        pkt_done_d  = 1'b0;
        pkt_good_d  = 1'b0;
        if (state == PAYLOAD && rx_valid) begin
            out_valid_d = 1'b1;
            beat_d.data = rx_data;
            beat_d.sop  = first_pay;
            beat_d.eop  = (pay_rem == 16'd1);
        end
        if ((state == PAYLOAD || state == TRAIL) && !rx_valid) begin
            pkt_done_d = 1'b1;
            pkt_good_d = (state == TRAIL) && (trail_cnt >= 3'd4) &&
                         (crc == CRC_RESIDUE) && !er_seen;
        end
    end

    // Per-frame bookkeeping: offset counter, MAC match flags, UDP length, payload/trail counts
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt     <= '0;
            mac_local_ok <= 1'b0;
            mac_bcast_ok <= 1'b0;
            udp_len      <= '0;
            pay_rem      <= '0;
            first_pay    <= 1'b0;
            er_seen      <= 1'b0;
            trail_cnt    <= '0;
        end else if (crc_init) begin
            byte_cnt     <= '0;
            mac_local_ok <= 1'b1;
            mac_bcast_ok <= 1'b1;
            first_pay    <= 1'b1;
            er_seen      <= 1'b0;
            trail_cnt    <= '0;
        end else if (rx_valid && (state inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TRAIL})) begin
            if (byte_cnt != '1) byte_cnt <= byte_cnt + 11'd1;
            if (byte_cnt <= OFF_MAC_LAST) begin
                mac_local_ok <= mac_local_ok && local_byte_ok;
                mac_bcast_ok <= mac_bcast_ok && bcast_byte_ok;
            end
            if (byte_cnt == OFF_UDP_LEN_HI) udp_len[15:8] <= rx_data;
            if (byte_cnt == OFF_UDP_LEN_LO) udp_len[7:0]  <= rx_data;
            if (byte_cnt == OFF_UDP_LAST)   pay_rem       <= udp_len - UDP_HDR_LEN;
            if (state == PAYLOAD) begin
                pay_rem   <= pay_rem - 16'd1;
                first_pay <= 1'b0;
            end
            if (state == TRAIL && trail_cnt != 3'd4) trail_cnt <= trail_cnt + 3'd1;
            if (rx_er) er_seen <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_good  <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            out_data  <= beat_d.data;
            out_valid <= out_valid_d;
            out_sop   <= beat_d.sop;
            out_eop   <= beat_d.eop;
            pkt_done  <= pkt_done_d;
            pkt_good  <= pkt_good_d;
            if (drop_inc) drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule
